// File: rtl/booth_seq_mul.sv
// booth_seq_mul: sequential radix-2 Booth multiplier for signed WIDTH-bit operands.
// Start/busy/done handshake; the 2*WIDTH-bit product is registered and held
// until the next operation completes.
// Optional feature macro: BOOTH_EARLY_EXIT_EN -- finishes early once every
// remaining Booth pair is a no-op, using a single barrel shift of {A,Q}.
module booth_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r, state_n_s;
    logic [WIDTH:0]         a_r, a_n_s;        // accumulator with sign guard bit
    logic [WIDTH:0]         m_r, m_n_s;        // sign-extended multiplicand
    logic [WIDTH-1:0]       q_r, q_n_s;        // multiplier / low product half
    logic                   q1_r, q1_n_s;      // Booth look-behind bit
    logic [CNT_W-1:0]       count_r, count_n_s;
    logic [2*WIDTH-1:0]     product_r, product_n_s;
    logic                   busy_r, done_r;
    logic [WIDTH:0]         sum_s;
    logic [2*WIDTH+1:0]     step_s;            // {A,Q,q_1} after add and shift

`ifdef BOOTH_EARLY_EXIT_EN
    logic                   ee_hit_s;
    logic [2*WIDTH:0]       ee_shift_s;

    // Detect that every remaining multiplier bit equals q_1 (all pairs no-op)
    always_comb begin
        ee_hit_s = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if ((CNT_W'(i) < count_r) && (q_r[i] != q1_r)) begin
                ee_hit_s = 1'b0;
            end else begin
                ee_hit_s = ee_hit_s;
            end
        end
    end

    // Collapse all remaining shifts into one arithmetic shift
    assign ee_shift_s = $signed({a_r, q_r}) >>> count_r;
`endif

    // Booth recoding of {Q[0],q_1}: add, subtract or pass the accumulator
    always_comb begin
        sum_s = a_r;
        case ({q_r[0], q1_r})
            2'b01:   sum_s = a_r + m_r;
            2'b10:   sum_s = a_r - m_r;
            default: sum_s = a_r;
        endcase
    end

    // Arithmetic shift right of {A,Q,q_1}, replicating the guard bit
    assign step_s = $signed({sum_s, q_r, q1_r}) >>> 1;

    // Next-state and datapath next values
    always_comb begin
        state_n_s   = state_r;
        a_n_s       = a_r;
        m_n_s       = m_r;
        q_n_s       = q_r;
        q1_n_s      = q1_r;
        count_n_s   = count_r;
        product_n_s = product_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    m_n_s     = {multiplicand[WIDTH-1], multiplicand};
                    a_n_s     = {(WIDTH+1){1'b0}};
                    q_n_s     = multiplier;
                    q1_n_s    = 1'b0;
                    count_n_s = CNT_LOAD;
                    state_n_s = RUN;
                end else begin
                    state_n_s = IDLE;
                end
            end
            RUN: begin
`ifdef BOOTH_EARLY_EXIT_EN
                if (ee_hit_s) begin
                    a_n_s       = ee_shift_s[2*WIDTH:WIDTH];
                    q_n_s       = ee_shift_s[WIDTH-1:0];
                    count_n_s   = {CNT_W{1'b0}};
                    product_n_s = ee_shift_s[2*WIDTH-1:0];
                    state_n_s   = DONE;
                end else begin
`endif
                    a_n_s     = step_s[2*WIDTH+1:WIDTH+1];
                    q_n_s     = step_s[WIDTH:1];
                    q1_n_s    = step_s[0];
                    count_n_s = count_r - CNT_ONE;
                    if (count_r == CNT_ONE) begin
                        product_n_s = step_s[2*WIDTH:1];
                        state_n_s   = DONE;
                    end else begin
                        state_n_s   = RUN;
                    end
`ifdef BOOTH_EARLY_EXIT_EN
                end
`endif
            end
            default: state_n_s = IDLE;
        endcase
    end

    // State register and registered handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n_s;
            busy_r  <= (state_n_s == RUN);
            done_r  <= (state_n_s == DONE);
        end
    end

    // Datapath registers; reset discards any partial result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r       <= {(WIDTH+1){1'b0}};
            m_r       <= {(WIDTH+1){1'b0}};
            q_r       <= {WIDTH{1'b0}};
            q1_r      <= 1'b0;
            count_r   <= {CNT_W{1'b0}};
            product_r <= {(2*WIDTH){1'b0}};
        end else begin
            a_r       <= a_n_s;
            m_r       <= m_n_s;
            q_r       <= q_n_s;
            q1_r      <= q1_n_s;
            count_r   <= count_n_s;
            product_r <= product_n_s;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule
